// File: rtl/clock_enable_gen_if.sv
// -----------------------------------------------------------------------------
// clock_enable_gen_if
//
// Purpose: groups the increment-write bus and the enable outputs of
// clock_enable_gen into one bundle.
//
// Parameters:
//   CHANNELS  - number of enable channels (1..16)
//   ACC_WIDTH - phase-accumulator / increment width in bits (8..32)
//
// Signals:
//   wr_en   - increment-write strobe
//   wr_ch   - target channel of the write (CH_W bits)
//   wr_inc  - new increment value
//   wr_clr  - with wr_en, also clears the target channel's accumulator
//   en      - one-cycle clock-enable pulse per channel
//   tgl     - 50%-duty toggle per channel (constant 0 unless enabled)
//   lock    - high once the post-reset settling period has elapsed
//
// Modports:
//   master - drives the write bus, observes the outputs
//   slave  - the generator itself
// -----------------------------------------------------------------------------
interface clock_enable_gen_if #(
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 24
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [ACC_WIDTH-1:0] wr_inc;
  logic                 wr_clr;
  logic [CHANNELS-1:0]  en;
  logic [CHANNELS-1:0]  tgl;
  logic                 lock;

  modport master (
    output wr_en, wr_ch, wr_inc, wr_clr,
    input  en, tgl, lock
  );

  modport slave (
    input  wr_en, wr_ch, wr_inc, wr_clr,
    output en, tgl, lock
  );
endinterface

// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
//
// Purpose: multi-channel phase-accumulator clock-enable generator. Each
// channel adds its increment to an accumulator every locked cycle; the carry
// out of the add becomes a one-cycle enable pulse, giving an average rate of
// f_clk * inc / 2^ACC_WIDTH. A lock counter holds all channels idle for
// LOCK_CYCLES cycles after reset release.
//
// Parameters:
//   CHANNELS    - number of independent channels (1..16)
//   ACC_WIDTH   - accumulator / increment width (8..32)
//   INIT_INC    - increment loaded into every channel at reset
//   LOCK_CYCLES - cycles from reset release until lock (1..65535)
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - clock_enable_gen_if.slave (wr_en/wr_ch/wr_inc/wr_clr in,
//           en/tgl/lock out)
//
// Optional feature macro: CLOCK_ENABLE_GEN_TGL_OUT_EN
//   Defined   : tgl[ch] inverts each cycle en[ch] is high, cleared by wr_clr.
//   Undefined : tgl is tied to 0 and no toggle registers exist.
// -----------------------------------------------------------------------------
module clock_enable_gen #(
  parameter int CHANNELS    = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int INIT_INC    = 0,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  clock_enable_gen_if.slave  bus
);

  localparam int                   CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [15:0]          LOCK_LAST  = 16'(LOCK_CYCLES - 1);
  localparam logic [ACC_WIDTH-1:0] INIT_INC_V = ACC_WIDTH'(INIT_INC);

  logic                r_lock;
  logic [15:0]         r_lock_cnt;
  logic [CHANNELS-1:0] r_en;

  // Lock sequencing: the counter runs only until lock is reached, so lock
  // stays high until the next reset without the counter wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end else if (!r_lock) begin
      r_lock_cnt <= r_lock_cnt + 16'd1;
      if (r_lock_cnt == LOCK_LAST) begin
        r_lock <= 1'b1;
      end
    end
  end

`ifdef CLOCK_ENABLE_GEN_TGL_OUT_EN
  logic [CHANNELS-1:0] r_tgl;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_ch
      logic [ACC_WIDTH-1:0] r_acc;
      logic [ACC_WIDTH-1:0] r_inc;
      logic [ACC_WIDTH:0]   w_sum;
      logic                 w_wr_sel;
      logic                 w_wr_clr;

      // One extra bit holds the carry that becomes the enable pulse.
      assign w_sum    = {1'b0, r_acc} + {1'b0, r_inc};
      // Out-of-range channel codes match no channel, so such writes vanish.
      assign w_wr_sel = bus.wr_en && (bus.wr_ch == CH_W'(gi));
      assign w_wr_clr = w_wr_sel && bus.wr_clr;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_acc    <= '0;
          r_inc    <= INIT_INC_V;
          r_en[gi] <= 1'b0;
        end else begin
          // The add below still sees the old r_inc in the write cycle.
          if (w_wr_sel) begin
            r_inc <= bus.wr_inc;
          end
          if (w_wr_clr) begin
            // Clear wins over any carry produced in the same cycle.
            r_acc    <= '0;
            r_en[gi] <= 1'b0;
          end else if (r_lock) begin
            r_acc    <= w_sum[ACC_WIDTH-1:0];
            r_en[gi] <= w_sum[ACC_WIDTH];
          end else begin
            r_acc    <= '0;
            r_en[gi] <= 1'b0;
          end
        end
      end

`ifdef CLOCK_ENABLE_GEN_TGL_OUT_EN
      // Toggle on the registered pulse, so tgl trails en by one cycle and
      // its period is twice the enable period.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tgl[gi] <= 1'b0;
        end else if (w_wr_clr) begin
          r_tgl[gi] <= 1'b0;
        end else if (r_en[gi]) begin
          r_tgl[gi] <= ~r_tgl[gi];
        end
      end
`endif
    end
  endgenerate

  assign bus.en   = r_en;
  assign bus.lock = r_lock;

`ifdef CLOCK_ENABLE_GEN_TGL_OUT_EN
  assign bus.tgl = r_tgl;
`else
  assign bus.tgl = '0;
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Directed bench for clock_enable_gen. A cycle-level arithmetic model of the
// accumulators runs alongside the DUT and is compared every cycle; literal
// hand-computed pulse/toggle patterns and counts pin the model itself.
// Five channels are used so the 3-bit channel select has out-of-range codes.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

  localparam int CHN   = 5;
  localparam int AW    = 24;
  localparam int INITI = 0;
  localparam int LOCKC = 16;
  localparam int CH_W  = 3;
  localparam longint MOD = 64'd1 << AW;

`ifdef CLOCK_ENABLE_GEN_TGL_OUT_EN
  localparam bit TGL_ON = 1'b1;
`else
  localparam bit TGL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  clock_enable_gen_if #(.CHANNELS(CHN), .ACC_WIDTH(AW)) bus ();

  clock_enable_gen #(
    .CHANNELS   (CHN),
    .ACC_WIDTH  (AW),
    .INIT_INC   (INITI),
    .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_acc [CHN];
  longint m_inc [CHN];
  bit     m_en  [CHN];
  bit     m_tgl [CHN];
  int     m_cycles;
  bit     m_lock;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHN; c++) begin
        m_acc[c] = 0;
        m_inc[c] = INITI;
        m_en[c]  = 0;
        m_tgl[c] = 0;
      end
      m_cycles = 0;
      m_lock   = 0;
    end else begin
      for (int c = 0; c < CHN; c++) begin
        longint s;
        bit nxt_en;
        nxt_en = 0;
        if (m_lock) begin
          s      = m_acc[c] + m_inc[c];
          nxt_en = (s >= MOD);
          m_acc[c] = s % MOD;
        end
        if (m_en[c]) m_tgl[c] = !m_tgl[c];
        if (bus.wr_en && int'(bus.wr_ch) == c) begin
          m_inc[c] = longint'(bus.wr_inc);
          if (bus.wr_clr) begin
            m_acc[c] = 0;
            nxt_en   = 0;
            m_tgl[c] = 0;
          end
        end
        m_en[c] = nxt_en;
      end
      m_cycles++;
      if (m_cycles >= LOCKC) m_lock = 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [CHN-1:0] exp_en;
    logic [CHN-1:0] exp_tgl;
    if (!reset) begin
      for (int c = 0; c < CHN; c++) begin
        exp_en[c]  = m_en[c];
        exp_tgl[c] = TGL_ON ? m_tgl[c] : 1'b0;
      end
      chk("model_en",   longint'(bus.en),   longint'(exp_en));
      chk("model_tgl",  longint'(bus.tgl),  longint'(exp_tgl));
      chk("model_lock", longint'(bus.lock), longint'(m_lock));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr_set(input int ch, input longint inc, input bit clr);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = CH_W'(ch);
    bus.wr_inc = AW'(inc);
    bus.wr_clr = clr;
  endtask

  task automatic wr_idle();
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_inc = '0;
    bus.wr_clr = 1'b0;
  endtask

  task automatic lock_sequence(input string tag);
    for (int i = 1; i <= LOCKC; i++) begin
      @(negedge clk);
      chk({tag, "_lock"}, longint'(bus.lock), longint'(i == LOCKC));
      chk({tag, "_en_idle"}, longint'(bus.en), 0);
    end
  endtask

  int cnt0, cnt1, cnt2, cnt34, cnt_all;

  initial begin
    reset = 1'b1;
    wr_idle();
    repeat (3) @(negedge clk);
    chk("rst_en",   longint'(bus.en),   0);
    chk("rst_tgl",  longint'(bus.tgl),  0);
    chk("rst_lock", longint'(bus.lock), 0);
    $display("reset held: en=%0h tgl=%0h lock=%0b", bus.en, bus.tgl, bus.lock);

    // Lock rises on the 16th cycle after release, en stays 0.
    reset = 1'b0;
    lock_sequence("lock1");
    $display("lock sequence 1 done: lock=%0b", bus.lock);

    // ch0 at half rate, then a write in a carry cycle, then a clearing write.
    wr_set(0, 64'h800000, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      wr_idle();
      chk("ch0_en_pattern", longint'(bus.en[0]),
          longint'(k inside {3, 5, 7, 9, 13, 21, 25, 29}));
      chk("ch0_tgl_pattern", longint'(bus.tgl[0]),
          longint'(TGL_ON && (k inside {4, 5, 8, 9, 14, 15, 16, 22, 23, 24, 25, 30})));
      $display("ch0 k=%0d en0=%0b tgl0=%0b", k, bus.en[0], bus.tgl[0]);
      if (k == 8)  wr_set(0, 64'h400000, 1'b0);
      if (k == 16) wr_set(0, 64'h400000, 1'b1);
    end

    // Rate check on ch1 and ch2.
    wr_set(1, 64'h400000, 1'b0);
    @(negedge clk);
    wr_set(2, 64'h555555, 1'b0);
    @(negedge clk);
    wr_idle();
    cnt1 = 0;
    cnt2 = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      cnt1 += int'(bus.en[1]);
      cnt2 += int'(bus.en[2]);
    end
    chk("ch1_count", cnt1, 750);
    checks++;
    if (!(cnt2 == 999 || cnt2 == 1000)) begin
      errors++;
      $display("FAIL ch2_count: got %0d, expected 999 or 1000", cnt2);
    end
    $display("rate: ch1=%0d ch2=%0d pulses over 3000 cycles", cnt1, cnt2);

    // Out-of-range channel writes must change nothing.
    wr_set(7, 64'h123456, 1'b1);
    @(negedge clk);
    wr_set(5, 64'hFFFFFF, 1'b1);
    @(negedge clk);
    wr_idle();
    cnt0  = 0;
    cnt34 = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cnt0  += int'(bus.en[0]);
      cnt34 += int'(bus.en[3]) + int'(bus.en[4]);
    end
    chk("oor_ch0_count", cnt0, 10);
    chk("oor_ch34_count", cnt34, 0);
    $display("out-of-range writes: ch0=%0d ch3+ch4=%0d pulses in 40 cycles", cnt0, cnt34);

    // inc=0 stops a channel.
    wr_set(1, 64'h0, 1'b0);
    @(negedge clk);
    wr_idle();
    cnt1 = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cnt1 += int'(bus.en[1]);
    end
    chk("ch1_stopped", cnt1, 0);
    $display("ch1 inc=0: %0d pulses in 40 cycles", cnt1);

    // Mid-run asynchronous reset.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_en",   longint'(bus.en),   0);
    chk("async_rst_tgl",  longint'(bus.tgl),  0);
    chk("async_rst_lock", longint'(bus.lock), 0);
    $display("mid-run reset: en=%0h tgl=%0h lock=%0b", bus.en, bus.tgl, bus.lock);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lock_sequence("lock2");
    cnt_all = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cnt_all += $countones(bus.en);
    end
    chk("init_inc_idle", cnt_all, 0);
    $display("after relock: %0d pulses in 40 cycles with reset increments", cnt_all);

    // Toggle period after relock at half rate.
    wr_set(0, 64'h800000, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      wr_idle();
      chk("relock_en0", longint'(bus.en[0]), longint'(k inside {3, 5, 7, 9, 11}));
      chk("relock_tgl0", longint'(bus.tgl[0]),
          longint'(TGL_ON && (k inside {4, 5, 8, 9, 12})));
      $display("relock k=%0d en0=%0b tgl0=%0b", k, bus.en[0], bus.tgl[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
